// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } arb_state_e;

  localparam int DEF_DATA_W        = 8;
  localparam int DEF_GAP_TICKS     = 16;
  localparam int DEF_TIMEOUT_TICKS = 256;

  // Counter width able to hold max_val; never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Round-robin search: first set request bit after index i_last, wrapping at N-1.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);

  logic [IW-1:0] cand_idx [N];
  logic [N-1:0]  cand_req;

  genvar gi;
  for (gi = 0; gi < N; gi++) begin : g_cand
    assign cand_idx[gi] = IW'((int'(i_last) + gi + 1) % N);
    assign cand_req[gi] = i_req[cand_idx[gi]];
  end

  // Walk from the farthest offset down so the nearest requester wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        o_found = 1'b1;
        o_idx   = cand_idx[k];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding one UART transmitter, with an inter-frame guard gap.
// Define UART_TX_ARB_TIMEOUT_EN to add the WAIT_DONE watchdog (o_timeout).
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int GAP_TICKS     = DEF_GAP_TICKS,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_b_tick,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  i_req_data,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic                       o_tx_start,
  output logic [DATA_W-1:0]          o_tx_data,
  input  logic                       i_tx_busy,
  input  logic                       i_tx_done,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
  output logic                       o_timeout
);

  localparam int IW    = $clog2(NUM_REQ);
  localparam int GAP_W = cnt_w(GAP_TICKS);
  localparam logic [IW-1:0]    LAST_INIT = IW'(NUM_REQ - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_TICKS - 1);

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     last_grant_q, last_grant_d;
  logic [IW-1:0]     grant_id_q, grant_id_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              pick_found;
  logic [IW-1:0]     pick_idx;
  logic              grant;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TO_W = cnt_w(TIMEOUT_TICKS);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_c;
`endif

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .i_req   (i_req_valid),
    .i_last  (last_grant_q),
    .o_found (pick_found),
    .o_idx   (pick_idx)
  );

  // The pop pulse is combinational on i_req_valid, so it must be masked while rst is held.
  assign grant       = (state_q == IDLE) && pick_found && !rst;
  assign o_req_ready = grant ? (NUM_REQ'(1) << pick_idx) : '0;
  assign o_tx_data   = tx_data_q;
  assign o_grant_id  = grant_id_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    tx_data_d    = tx_data_q;
    gap_cnt_d    = gap_cnt_q;
    o_tx_start   = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
    timeout_c    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d      = START;
          last_grant_d = pick_idx;
          grant_id_d   = pick_idx;
          tx_data_d    = i_req_data[int'(pick_idx)*DATA_W +: DATA_W];
        end
      end
      START: begin
        if (!i_tx_busy) begin
          o_tx_start = 1'b1;
          state_d    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (i_tx_done) begin
          state_d = (GAP_TICKS == 0) ? IDLE : GAP;
`ifdef UART_TX_ARB_TIMEOUT_EN
        end else if (i_b_tick) begin
          if (to_cnt_q == TO_LAST) begin
            timeout_c = 1'b1;
            state_d   = IDLE;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
`endif
        end
      end
      GAP: begin
        if (i_b_tick) begin
          if (gap_cnt_q == GAP_LAST) state_d = IDLE;
          else gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Every state entry starts its counters from zero.
    if (state_d != state_q) begin
      gap_cnt_d = '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      to_cnt_d  = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_INIT;
      grant_id_q   <= '0;
      tx_data_q    <= '0;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      tx_data_q    <= tx_data_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end

  assign o_timeout = timeout_c;
`else
  assign o_timeout = 1'b0;
`endif

endmodule
